// File: rtl/rt_pkg.sv
// Shared definitions for the reaction-timer controller: state encodings,
// LFSR constants and small arithmetic helpers.
package rt_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_PREP   = 3'd1,
        ST_TEST   = 3'd2,
        ST_RESULT = 3'd3,
        ST_FAULT  = 3'd4
    } rt_state_t;

    localparam logic [15:0] LFSR_SEED      = 16'hACE1;
    // Right-shifting Galois mask for x^16 + x^14 + x^13 + x^11 + 1.
    localparam logic [15:0] LFSR_TAPS      = 16'hB400;
    localparam logic [3:0]  BCD_MAX_DIGIT  = 4'd9;
    localparam int          BCD_MAX_DIGITS = 8;
    localparam int          BCD_CMP_W      = 4 * BCD_MAX_DIGITS;

    function automatic int tick_divisor(input int clk_hz, input int tick_hz);
        int div;
        div = (tick_hz > 0) ? clk_hz / tick_hz : 1;
        return (div < 1) ? 1 : div;
    endfunction

    function automatic logic [15:0] lfsr_next(input logic [15:0] cur);
        return {1'b0, cur[15:1]} ^ ({16{cur[0]}} & LFSR_TAPS);
    endfunction

    // Numeric compare of two BCD values, most significant digit decides.
    function automatic logic bcd_lt(input logic [BCD_CMP_W-1:0] a,
                                    input logic [BCD_CMP_W-1:0] b);
        logic lt;
        logic decided;
        lt      = 1'b0;
        decided = 1'b0;
        for (int i = BCD_MAX_DIGITS - 1; i >= 0; i--) begin
            if (!decided && (a[4*i +: 4] != b[4*i +: 4])) begin
                lt      = (a[4*i +: 4] < b[4*i +: 4]);
                decided = 1'b1;
            end
        end
        return lt;
    endfunction

endpackage

// File: rtl/reaction_timer_ctrl_bcd_counter.sv
// Multi-digit BCD up-counter with synchronous clear; saturates at all nines
// so a caller can detect overflow from all_nines before incrementing.
module bcd_counter
    import rt_pkg::*;
#(
    parameter int DIGITS = 4
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                clr,
    input  logic                inc,
    output logic [4*DIGITS-1:0] value,
    output logic                all_nines
);

    logic [4*DIGITS-1:0] value_d;
    logic                carry;

    always_comb begin
        all_nines = 1'b1;
        for (int i = 0; i < DIGITS; i++) begin
            if (value[4*i +: 4] != BCD_MAX_DIGIT) all_nines = 1'b0;
        end
    end

    // NOTE: every always_comb output gets a default first so no latch is inferred.
    always_comb begin
        value_d = value;
        carry   = inc && !all_nines;
        for (int i = 0; i < DIGITS; i++) begin
            if (carry) begin
                if (value[4*i +: 4] == BCD_MAX_DIGIT) begin
                    value_d[4*i +: 4] = 4'd0;
                end else begin
                    value_d[4*i +: 4] = value[4*i +: 4] + 4'd1;
                    carry             = 1'b0;
                end
            end
        end
        if (clr) value_d = '0;
    end

    // NOTE: sequential state uses non-blocking assignments only.
    always_ff @(posedge clk) begin
        if (reset) value <= '0;
        else       value <= value_d;
    end

endmodule

// File: rtl/reaction_timer_ctrl.sv
// Reaction-timer controller: IDLE -> PREP (random delay) -> TEST -> RESULT,
// with false-start detection, BCD reaction count and session best time.
module reaction_timer_ctrl
    import rt_pkg::*;
#(
    parameter int CLK_HZ         = 100_000_000,
    parameter int TICK_HZ        = 1000,
    parameter int DIGITS         = 4,
    parameter int PREP_MIN_TICKS = 1000,
    parameter int PREP_RAND_BITS = 11,
    parameter int HOLD_TICKS     = 5000
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                start,
    input  logic                stop,
    input  logic                abort,
    output logic [2:0]          state,
    output logic [4*DIGITS-1:0] time_bcd,
    output logic [4*DIGITS-1:0] best_bcd,
    output logic                test_active,
    output logic                false_start,
    output logic                overflow,
    output logic                new_best
);

    localparam int TICK_DIV = tick_divisor(CLK_HZ, TICK_HZ);
    localparam int TICK_W   = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int PREP_MAX = PREP_MIN_TICKS + (2 ** PREP_RAND_BITS) - 1;
    localparam int PREP_W   = $clog2(PREP_MAX + 1);
    localparam int HOLD_W   = (HOLD_TICKS > 1) ? $clog2(HOLD_TICKS + 1) : 1;

    rt_state_t           state_q, state_d;
    logic [15:0]         lfsr;
    logic [TICK_W-1:0]   tick_cnt;
    logic [PREP_W-1:0]   prep_cnt, prep_target;
    logic [HOLD_W-1:0]   hold_cnt;
    logic                tick, prep_done, hold_done, cnt_clr;
    logic                bcd_clr, bcd_inc, all_nines;
    logic                load_target, set_ovf, take_best;

    assign state     = state_q;
    assign tick      = (tick_cnt == TICK_W'(TICK_DIV - 1));
    assign prep_done = tick && (prep_cnt == prep_target - PREP_W'(1));
    assign hold_done = tick && (hold_cnt == HOLD_W'(HOLD_TICKS - 1));
    // Running counters restart on every state change and on abort.
    assign cnt_clr   = (state_d != state_q) || abort;

    bcd_counter #(.DIGITS(DIGITS)) u_time (
        .clk       (clk),
        .reset     (reset),
        .clr       (bcd_clr),
        .inc       (bcd_inc),
        .value     (time_bcd),
        .all_nines (all_nines)
    );

    always_comb begin
        state_d     = state_q;
        bcd_clr     = 1'b0;
        bcd_inc     = 1'b0;
        load_target = 1'b0;
        set_ovf     = 1'b0;
        take_best   = 1'b0;
        if (abort) begin
            state_d = ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (start) begin
                        state_d     = ST_PREP;
                        bcd_clr     = 1'b1;
                        load_target = 1'b1;
                    end
                end
                ST_PREP: begin
                    if (stop)           state_d = ST_FAULT;
                    else if (prep_done) state_d = ST_TEST;
                end
                ST_TEST: begin
                    if (stop) begin
                        state_d   = ST_RESULT;
                        take_best = !overflow &&
                                    bcd_lt(BCD_CMP_W'(time_bcd), BCD_CMP_W'(best_bcd));
                    end else if (tick) begin
                        if (all_nines) begin
                            set_ovf = 1'b1;
                            state_d = ST_RESULT;
                        end else begin
                            bcd_inc = 1'b1;
                        end
                    end
                end
                ST_RESULT, ST_FAULT: begin
                    if (hold_done) state_d = ST_IDLE;
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) lfsr <= LFSR_SEED;
        else       lfsr <= lfsr_next(lfsr);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            tick_cnt <= '0;
            prep_cnt <= '0;
            hold_cnt <= '0;
        end else if (cnt_clr) begin
            tick_cnt <= '0;
            prep_cnt <= '0;
            hold_cnt <= '0;
        end else begin
            tick_cnt <= tick ? '0 : tick_cnt + TICK_W'(1);
            if (tick && (state_q == ST_PREP))
                prep_cnt <= prep_cnt + PREP_W'(1);
            if (tick && ((state_q == ST_RESULT) || (state_q == ST_FAULT)))
                hold_cnt <= hold_cnt + HOLD_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            prep_target <= '0;
            best_bcd    <= {DIGITS{BCD_MAX_DIGIT}};
            overflow    <= 1'b0;
            new_best    <= 1'b0;
            test_active <= 1'b0;
            false_start <= 1'b0;
        end else begin
            state_q <= state_d;
            if (load_target)
                prep_target <= PREP_W'(PREP_MIN_TICKS) + PREP_W'(lfsr[PREP_RAND_BITS-1:0]);
            if (load_target)  overflow <= 1'b0;
            else if (set_ovf) overflow <= 1'b1;
            if (take_best) best_bcd <= time_bcd;
            new_best    <= take_best;
            test_active <= (state_d == ST_TEST);
            false_start <= (state_d == ST_FAULT);
        end
    end

endmodule

// File: tb/tb_reaction_timer_ctrl.sv
// Self-checking bench: directed scenarios plus random pulses, compared every
// cycle against an integer-level model of the trial rules.
module tb_reaction_timer_ctrl;

    localparam int DIGITS    = 3;
    localparam int DIV       = 10;
    localparam int PREP_MIN  = 5;
    localparam int RAND_BITS = 2;
    localparam int HOLD      = 3;
    localparam int MAXV      = 999;

    localparam int S_IDLE = 0, S_PREP = 1, S_TEST = 2, S_RESULT = 3, S_FAULT = 4;

    logic        clk = 1'b0;
    logic        reset = 1'b1, start = 1'b0, stop = 1'b0, abort = 1'b0;
    logic [2:0]  state;
    logic [11:0] time_bcd, best_bcd;
    logic        test_active, false_start, overflow, new_best;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    reaction_timer_ctrl #(
        .CLK_HZ(1000), .TICK_HZ(100), .DIGITS(DIGITS),
        .PREP_MIN_TICKS(PREP_MIN), .PREP_RAND_BITS(RAND_BITS), .HOLD_TICKS(HOLD)
    ) dut (
        .clk(clk), .reset(reset), .start(start), .stop(stop), .abort(abort),
        .state(state), .time_bcd(time_bcd), .best_bcd(best_bcd),
        .test_active(test_active), .false_start(false_start),
        .overflow(overflow), .new_best(new_best)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference model: integer reaction time, cycles since state entry.
    int          m_state = 0, m_age = 0, m_ticks = 0, m_target = 0;
    int          m_time = 0, m_best = MAXV;
    bit          m_ovf = 0, m_newbest = 0;
    logic [15:0] m_lfsr = 16'hACE1;

    function automatic logic [11:0] to_bcd(input int v);
        return {4'(v / 100 % 10), 4'(v / 10 % 10), 4'(v % 10)};
    endfunction

    function automatic logic [15:0] lfsr_step(input logic [15:0] v);
        return (v >> 1) ^ (v[0] ? 16'hB400 : 16'h0000);
    endfunction

    always @(posedge clk) begin
        int nxt;
        bit tk;
        tk        = (m_age % DIV) == DIV - 1;
        m_newbest = 0;
        if (reset) begin
            m_state = S_IDLE; m_age = 0; m_ticks = 0; m_target = 0;
            m_time = 0; m_best = MAXV; m_ovf = 0; m_lfsr = 16'hACE1;
        end else begin
            nxt = m_state;
            if (abort) nxt = S_IDLE;
            else case (m_state)
                S_IDLE: if (start) begin
                    nxt      = S_PREP;
                    m_target = PREP_MIN + int'(m_lfsr % (1 << RAND_BITS));
                    m_time   = 0;
                    m_ovf    = 0;
                end
                S_PREP: if (stop) nxt = S_FAULT;
                        else if (tk && m_ticks + 1 == m_target) nxt = S_TEST;
                S_TEST: if (stop) begin
                    nxt = S_RESULT;
                    if (m_time < m_best) begin m_best = m_time; m_newbest = 1; end
                end else if (tk) begin
                    if (m_time == MAXV) begin m_ovf = 1; nxt = S_RESULT; end
                    else m_time++;
                end
                default: if (tk && m_ticks + 1 == HOLD) nxt = S_IDLE;
            endcase
            if (nxt != m_state || abort) begin m_age = 0; m_ticks = 0; end
            else begin m_age++; if (tk) m_ticks++; end
            m_state = nxt;
            m_lfsr  = lfsr_step(m_lfsr);
        end
    end

    task automatic model_check();
        check("m_state", state, m_state);
        check("m_time", time_bcd, to_bcd(m_time));
        check("m_best", best_bcd, to_bcd(m_best));
        check("m_active", test_active, m_state == S_TEST);
        check("m_false", false_start, m_state == S_FAULT);
        check("m_ovf", overflow, m_ovf);
        check("m_newbest", new_best, m_newbest);
    endtask

    // Drive one cycle of pulses at the falling edge, check at the next one.
    task automatic step(input bit s, input bit p, input bit a, input bit r);
        start = s; stop = p; abort = a; reset = r;
        @(posedge clk);
        @(negedge clk);
        start = 0; stop = 0; abort = 0; reset = 0;
        model_check();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(0, 0, 0, 0);
    endtask

    task automatic wait_state(input string tag, input int target, input int budget);
        int n = 0;
        while (m_state != target && n < budget) begin step(0, 0, 0, 0); n++; end
        check(tag, state, target);
    endtask

    // Start a trial and stop it stop_age cycles after TEST entry.
    task automatic trial(input int stop_age);
        step(1, 0, 0, 0);
        wait_state("to_test", S_TEST, 200);
        idle(stop_age);
        step(0, 1, 0, 0);
    endtask

    initial begin
        int n;
        @(negedge clk);
        step(0, 0, 0, 1);
        step(0, 0, 0, 1);
        check("rst_state", state, S_IDLE);
        check("rst_best", best_bcd, 12'h999);
        check("rst_time", time_bcd, 12'h000);

        // Normal trial: 23 ticks before stop.
        trial(235);
        check("t1_time", time_bcd, 12'h023);
        check("t1_state", state, S_RESULT);
        check("t1_best", best_bcd, 12'h023);
        check("t1_newbest", new_best, 1);
        step(0, 0, 0, 0);
        check("t1_newbest_off", new_best, 0);
        idle(28);
        check("t1_hold", state, S_RESULT);
        step(0, 0, 0, 0);
        check("t1_idle", state, S_IDLE);

        // False start.
        step(1, 0, 0, 0);
        idle(20);
        step(0, 1, 0, 0);
        check("t2_state", state, S_FAULT);
        check("t2_false", false_start, 1);
        check("t2_time", time_bcd, 12'h000);
        check("t2_best", best_bcd, 12'h023);
        idle(29);
        check("t2_hold", state, S_FAULT);
        step(0, 0, 0, 0);
        check("t2_idle", state, S_IDLE);

        // Overflow: no stop in TEST.
        step(1, 0, 0, 0);
        wait_state("t3_test", S_TEST, 200);
        n = 0;
        while (m_state == S_TEST && n < 10100) begin step(0, 0, 0, 0); n++; end
        check("t3_cycles", n, 10000);
        check("t3_state", state, S_RESULT);
        check("t3_time", time_bcd, 12'h999);
        check("t3_ovf", overflow, 1);
        check("t3_best", best_bcd, 12'h023);
        wait_state("t3_idle", S_IDLE, 40);

        // Best tracking.
        step(0, 0, 0, 1);
        trial(405);
        check("t4_best1", best_bcd, 12'h040);
        check("t4_nb1", new_best, 1);
        wait_state("t4_idle1", S_IDLE, 40);
        trial(255);
        check("t4_best2", best_bcd, 12'h025);
        check("t4_nb2", new_best, 1);
        wait_state("t4_idle2", S_IDLE, 40);
        trial(255);
        check("t4_best3", best_bcd, 12'h025);
        check("t4_nb3", new_best, 0);
        wait_state("t4_idle3", S_IDLE, 40);

        // Collisions: stop on PREP target cycle, stop on a TEST tick.
        step(1, 0, 0, 0);
        idle(m_target * DIV - 1);
        step(0, 1, 0, 0);
        check("t5_fault", state, S_FAULT);
        wait_state("t5_idle", S_IDLE, 40);
        trial(49);
        check("t5_time", time_bcd, 12'h004);
        check("t5_best", best_bcd, 12'h004);
        wait_state("t5_idle2", S_IDLE, 40);

        // Abort mid-TEST, then reset during RESULT.
        step(1, 0, 0, 0);
        wait_state("t6_test", S_TEST, 200);
        idle(100);
        step(0, 0, 1, 0);
        check("t6_abort", state, S_IDLE);
        check("t6_time", time_bcd, 12'h010);
        check("t6_best", best_bcd, 12'h004);
        trial(35);
        check("t6_result", state, S_RESULT);
        step(0, 0, 0, 1);
        check("t6_rst_state", state, S_IDLE);
        check("t6_rst_time", time_bcd, 12'h000);
        check("t6_rst_best", best_bcd, 12'h999);
        check("t6_rst_nb", new_best, 0);

        // Random pulses against the model.
        for (int i = 0; i < 15000; i++) begin
            step($urandom_range(0, 19) == 0, $urandom_range(0, 29) == 0,
                 $urandom_range(0, 499) == 0, $urandom_range(0, 4999) == 0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/reaction_timer_ctrl.md
Name: reaction_timer_ctrl

Overview:
Parametrised reaction-timer controller. It is driven by single-cycle start/stop/abort pulses (already edge-detected upstream) and sequences IDLE -> PREP -> TEST -> RESULT. The PREP delay is pseudo-random, and a stop during PREP is flagged as a false start. Reaction time is counted in BCD at a parametrised tick rate, and the block keeps a session best time. It feeds the SSD driver and LED bank directly; the internal tick generator replaces external divided clocks, so everything runs on clk.

Parameters:
CLK_HZ, 100_000_000, system clock frequency
TICK_HZ, 1000, reaction-count resolution (1 ms default)
DIGITS, 4, BCD digits of reaction time (1..8)
PREP_MIN_TICKS, 1000, minimum PREP duration in ticks
PREP_RAND_BITS, 11, random extra PREP ticks, range 0..2^PREP_RAND_BITS-1
HOLD_TICKS, 5000, dwell time in RESULT and FAULT before returning to IDLE

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-high
start  in  1  one-cycle pulse, begins a trial from IDLE
stop  in  1  one-cycle pulse, subject response
abort  in  1  one-cycle pulse, return to IDLE from any state
state  out  3  current state encoding (package constants)
time_bcd  out  4*DIGITS  current/last reaction time, digit 0 = LSD
best_bcd  out  4*DIGITS  best valid time this session
test_active  out  1  high in TEST (drives LEDs)
false_start  out  1  high in FAULT
overflow  out  1  last trial saturated the counter
new_best  out  1  one-cycle pulse when best_bcd updates

Behaviour:
- Reset: state=IDLE; time_bcd=0; best_bcd=all 9s; tick counter, PREP counter and hold counter=0; all flags 0; LFSR loaded with nonzero seed 16'hACE1.
- Priority: reset > abort > state-specific events. Abort in any state -> IDLE next cycle. Abort clears no registers except the running counters.
- Tick: a free-running divider emits a one-cycle tick every CLK_HZ/TICK_HZ clocks. The divider restarts at 0 on every state change, so the first tick in a state lands exactly CLK_HZ/TICK_HZ cycles after entry.
- LFSR: 16-bit Galois, polynomial x^16+x^14+x^13+x^11+1, advances every clk.
- IDLE: start -> PREP. On that transition, PREP target = PREP_MIN_TICKS + LFSR[PREP_RAND_BITS-1:0]; time_bcd cleared; overflow cleared. Stop is ignored.
- PREP: counts ticks.
  - stop -> FAULT.
  - Target reached -> TEST.
  - If stop and target are reached in the same cycle, FAULT wins.
- TEST: test_active=1. time_bcd increments by 1 per tick, with BCD digit carry done in the sub-module.
  - stop -> RESULT. time_bcd freezes at its value in the stop cycle.
  - If stop coincides with a tick, the increment is not applied.
  - Counter at all 9s when a tick arrives -> overflow=1, time_bcd stays all 9s, go to RESULT.
- RESULT: on entry, if !overflow and time_bcd < best_bcd (numeric BCD compare), best_bcd <= time_bcd and new_best pulses one cycle. Equal times do not update. After HOLD_TICKS ticks -> IDLE. Start is ignored until IDLE.
- FAULT: false_start=1, time_bcd untouched. After HOLD_TICKS ticks -> IDLE.
- Latency: every state change is visible on state one cycle after the triggering pulse.
- Outputs are registered; best_bcd persists across trials until reset.
- Unused state encodings -> IDLE.

Decomposition:
- Package rt_pkg: state encodings (IDLE=0, PREP=1, TEST=2, RESULT=3, FAULT=4), the LFSR seed and taps, and a function that computes the tick divisor from CLK_HZ/TICK_HZ.
- Sub-module bcd_counter: parameter DIGITS; ports clr, inc, value, all_nines. Reused later by the stopwatch.
- The BCD less-than comparison is a package function.

Test Plan:
All scenarios use CLK_HZ=1000, TICK_HZ=100 (tick every 10 cycles), DIGITS=3, PREP_MIN_TICKS=5, PREP_RAND_BITS=2, HOLD_TICKS=3.
1. Normal trial: after reset, pulse start, wait for TEST, then pulse stop 235 cycles later -> time_bcd=12'h023, state=RESULT, best_bcd=12'h023, new_best for 1 cycle, IDLE 30 cycles later.
2. False start: stop 20 cycles into PREP -> state=FAULT, false_start=1, time_bcd=0, best_bcd unchanged; IDLE after 30 cycles.
3. Overflow: no stop in TEST -> time_bcd reaches 12'h999, overflow=1, RESULT on the 1000th tick, best_bcd unchanged.
4. Best tracking: trials of 40, 25 and 25 ticks -> best_bcd=12'h040, then 12'h025. new_best pulses in trials 1 and 2 only.
5. Collisions: stop on the PREP target cycle -> FAULT. Stop on a tick cycle in TEST -> no increment.
6. Abort/reset mid-TEST: abort -> IDLE next cycle with best_bcd kept. Reset during RESULT -> all reset values, best_bcd=12'h999.
